// File: rtl/stereo_frame_sequencer.sv
`timescale 1ns/1ps
// stereo_frame_sequencer
//
// Frame-level gatekeeper between a camera/VDMA AXI4-Stream and the
// Stereovision core's image input. Frames are admitted only from a
// start-of-frame beat. Output tuser/tlast are regenerated from internal
// beat/line counters. Truncated frames are padded with zero beats, so the
// core always sees exactly HEIGHT*BPL beats. The next frame is held back
// until the core's disparity output has produced a full frame. The image
// select is latched only when a frame starts.
//
// Ports:
//   aclk, aresetn        clock, synchronous active-low reset
//   s_axis_*             source stream (tvalid/tready/tdata/tuser/tlast)
//   m_axis_*             stream to the core (tvalid/tready/tdata/tuser/tlast)
//   mon_tvalid/tready/tlast  snoop of the core's disparity output
//   switch_img_in/out    requested / applied image select
//   frame_done           1-cycle pulse when the core's output frame completes
//   err_sof              1-cycle pulse on an SOF arriving mid-frame
//   err_eol              1-cycle pulse on an input tlast in the wrong position
//   dropped_beats        saturating count of beats discarded while seeking SOF
//   busy                 high while a frame is in flight (PASS, PAD, DRAIN)
module stereo_frame_sequencer #(
  parameter int WIDTH                 = 3840,
  parameter int HEIGHT                = 2160,
  parameter int MAX_SAMPLES_PER_CLOCK = 4,
  parameter int AXIS_TDATA_WIDTH      = 96
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tuser,
  input  logic                        s_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tuser,
  output logic                        m_axis_tlast,
  input  logic                        mon_tvalid,
  input  logic                        mon_tready,
  input  logic                        mon_tlast,
  input  logic [3:0]                  switch_img_in,
  output logic [3:0]                  switch_img_out,
  output logic                        frame_done,
  output logic                        err_sof,
  output logic                        err_eol,
  output logic [15:0]                 dropped_beats,
  output logic                        busy
);

  localparam int BPL    = WIDTH / MAX_SAMPLES_PER_CLOCK;
  localparam int BEAT_W = (BPL > 1) ? $clog2(BPL) : 1;
  localparam int LINE_W = $clog2(HEIGHT + 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BPL - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(HEIGHT - 1);

  typedef enum logic [1:0] {SEEK, PASS, PAD, DRAIN} state_t;

  state_t              state_reg;
  logic [BEAT_W-1:0]   beat_cnt_reg;
  logic [LINE_W-1:0]   line_cnt_reg;
  logic [LINE_W-1:0]   out_lines_reg;
  logic                out_done_reg;
  logic                frame_done_reg;
  logic                err_sof_reg;
  logic                err_eol_reg;
  logic [15:0]         dropped_reg;
  logic [3:0]          switch_reg;

  logic at_first_beat;
  logic at_line_end;
  logic early_sof;
  logic m_beat;
  logic s_beat;
  logic frame_last_beat;
  logic mon_line;

  assign at_first_beat = (beat_cnt_reg == '0) && (line_cnt_reg == '0);
  assign at_line_end   = (beat_cnt_reg == BEAT_LAST);

  // Stream steering. PASS is a pure combinational wire-through so the
  // data path adds no latency; an SOF seen away from beat (0,0) is blocked
  // on both sides so it stays pending for the next SEEK.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    s_axis_tready = 1'b0;
    early_sof     = 1'b0;
    case (state_reg)
      SEEK: s_axis_tready = !s_axis_tuser;
      PASS: begin
        early_sof    = s_axis_tuser && !at_first_beat;
        m_axis_tdata = s_axis_tdata;
        if (!early_sof) begin
          m_axis_tvalid = s_axis_tvalid;
          s_axis_tready = m_axis_tready;
        end
      end
      PAD:     m_axis_tvalid = 1'b1;
      default: ;
    endcase
  end

  assign m_axis_tuser    = m_axis_tvalid && at_first_beat;
  assign m_axis_tlast    = m_axis_tvalid && at_line_end;
  assign m_beat          = m_axis_tvalid && m_axis_tready;
  assign s_beat          = s_axis_tvalid && s_axis_tready;
  assign frame_last_beat = m_beat && at_line_end && (line_cnt_reg == LINE_LAST);
  assign mon_line        = mon_tvalid && mon_tready && mon_tlast;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_reg      <= SEEK;
      beat_cnt_reg   <= '0;
      line_cnt_reg   <= '0;
      out_lines_reg  <= '0;
      out_done_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
      err_sof_reg    <= 1'b0;
      err_eol_reg    <= 1'b0;
      dropped_reg    <= '0;
      switch_reg     <= '0;
    end else begin
      err_sof_reg    <= 1'b0;
      err_eol_reg    <= 1'b0;
      frame_done_reg <= 1'b0;

      // Output-side line counter, independent of the input state machine.
      if (mon_line) begin
        if (out_lines_reg == LINE_LAST) begin
          out_lines_reg  <= '0;
          frame_done_reg <= 1'b1;
        end else begin
          out_lines_reg <= out_lines_reg + 1'b1;
        end
      end

      // Sticky completion flag: a completion arriving outside DRAIN is kept
      // until DRAIN consumes it; a fresh completion always wins over the clear.
      out_done_reg <= (mon_line && (out_lines_reg == LINE_LAST)) ||
                      (out_done_reg && (state_reg != DRAIN));

      if (m_beat) begin
        if (at_line_end) begin
          beat_cnt_reg <= '0;
          line_cnt_reg <= (line_cnt_reg == LINE_LAST) ? '0 : line_cnt_reg + 1'b1;
        end else begin
          beat_cnt_reg <= beat_cnt_reg + 1'b1;
        end
      end

      case (state_reg)
        SEEK: begin
          if (s_beat && (dropped_reg != 16'hFFFF)) begin
            dropped_reg <= dropped_reg + 16'd1;
          end
          if (s_axis_tvalid && s_axis_tuser) begin
            state_reg    <= PASS;
            switch_reg   <= switch_img_in;
            beat_cnt_reg <= '0;
            line_cnt_reg <= '0;
          end
        end
        PASS: begin
          if (s_axis_tvalid && early_sof) begin
            err_sof_reg <= 1'b1;
            state_reg   <= PAD;
          end else begin
            if (s_beat && (s_axis_tlast != at_line_end)) begin
              err_eol_reg <= 1'b1;
            end
            if (frame_last_beat) begin
              state_reg <= DRAIN;
            end
          end
        end
        PAD: begin
          if (frame_last_beat) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_done_reg) begin
            state_reg <= SEEK;
          end
        end
        default: state_reg <= SEEK;
      endcase
    end
  end

  assign switch_img_out = switch_reg;
  assign frame_done     = frame_done_reg;
  assign err_sof        = err_sof_reg;
  assign err_eol        = err_eol_reg;
  assign dropped_beats  = dropped_reg;
  assign busy           = (state_reg != SEEK);

endmodule

// File: doc/stereo_frame_sequencer.md
# stereo_frame_sequencer

Frame-level controller placed between the input AXI4-Stream (VDMA/camera side) and the Stereovision core's image slave port. It admits pixel data only from a start-of-frame beat and regenerates `tlast`/`tuser` from its own counters. It pads truncated frames with zeros so the core always receives exactly HEIGHT×(WIDTH/MAX_SAMPLES_PER_CLOCK) beats. It admits one frame at a time, holding the next until the core's disparity output has emitted a complete frame, and it latches `switch_img` only at frame boundaries.

## Interface
- WIDTH, 3840, pixels per line
- HEIGHT, 2160, lines per frame
- MAX_SAMPLES_PER_CLOCK, 4, pixels per beat; BPL = WIDTH/MAX_SAMPLES_PER_CLOCK beats per line (integer by construction)
- AXIS_TDATA_WIDTH, 96, stream data width

- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- s_axis_tvalid/tready/tdata/tuser/tlast  in/out/in/in/in  1/1/AXIS_TDATA_WIDTH/1/1  source stream
- m_axis_tvalid/tready/tdata/tuser/tlast  out/in/out/out/out  1/1/AXIS_TDATA_WIDTH/1/1  stream to core
- mon_tvalid, mon_tready, mon_tlast  in  1 each  snoop of the core's disparity output; a beat counts when mon_tvalid & mon_tready
- switch_img_in  in  4  requested image select
- switch_img_out  out  4  image select applied to the core
- frame_done  out  1  one-cycle pulse when the core's output frame completes
- err_sof  out  1  one-cycle pulse on an early SOF
- err_eol  out  1  one-cycle pulse on an input tlast mismatch
- dropped_beats  out  16  saturating count of beats discarded in SEEK
- busy  out  1  high in PASS, PAD and DRAIN

## Operation
- States: SEEK, PASS, PAD, DRAIN. Reset state is SEEK.
- Counters: beat_cnt (0..BPL-1) and line_cnt (0..HEIGHT-1) advance on each m_axis beat (m_axis_tvalid & m_axis_tready). Both cleared on entry to PASS.
- SEEK
  - m_axis_tvalid=0; s_axis_tready=!s_axis_tuser.
  - Non-SOF beats are consumed and discarded; dropped_beats +1, saturating at 0xFFFF.
  - When s_axis_tvalid & s_axis_tuser: go to PASS without consuming the beat, and latch switch_img_out<=switch_img_in in the same cycle.
- PASS (combinational pass-through)
  - m_axis_tvalid=s_axis_tvalid; m_axis_tdata=s_axis_tdata; s_axis_tready=m_axis_tready.
  - Exception: a beat with s_axis_tuser=1 while (beat_cnt,line_cnt)≠(0,0) sees s_axis_tready=0 and m_axis_tvalid=0. err_sof pulses and the state moves to PAD. That SOF beat stays pending for the next SEEK.
  - Input tlast is checked, never forwarded. On an accepted beat, s_axis_tlast≠(beat_cnt==BPL-1) pulses err_eol; the data is still forwarded.
  - After the last beat of the frame (beat_cnt=BPL-1, line_cnt=HEIGHT-1) is accepted: go to DRAIN.
- PAD
  - m_axis_tvalid=1, m_axis_tdata=0, s_axis_tready=0.
  - Counters continue. After the last beat of the frame is accepted: go to DRAIN.
- Output sideband in PASS and PAD: m_axis_tuser=(beat_cnt==0 && line_cnt==0); m_axis_tlast=(beat_cnt==BPL-1). Both are 0 when m_axis_tvalid=0.
- DRAIN
  - s_axis_tready=0, m_axis_tvalid=0.
  - Exit to SEEK when out_done is set; out_done clears on that transition.
- Output monitor (runs in every state)
  - out_lines increments on each counted mon beat with mon_tlast.
  - On reaching HEIGHT: out_lines clears, frame_done pulses the following cycle, and sticky out_done is set.
  - out_done set while not in DRAIN is held until DRAIN is entered. Nothing is lost if it coincides with a state transition.
- switch_img_out changes only on the SEEK→PASS transition. It is stable for the whole frame.

## Timing
- PASS data path has zero latency. tready/tvalid are combinational from the opposite side; no skid buffer.
- All registers and outputs clear on the rising edge with aresetn=0: state=SEEK, counters 0, out_done 0, switch_img_out 0, dropped_beats 0, pulses 0.
- Reset mid-frame abandons the frame; padding is not generated. m_axis_tvalid is 0 from the first cycle after the reset edge.
- Frame throughput is bounded by input duration plus core output completion. There is no overlap of frames inside the core.
- Counter widths: $clog2(BPL) and $clog2(HEIGHT+1); dropped_beats is 16 bits and saturates.

## Test plan
Use WIDTH=16, HEIGHT=4, MAX_SAMPLES_PER_CLOCK=4 (BPL=4, 16 beats per frame).
- Clean frame, m_tready=1, mon returns 4 tlast beats:
  - Required: 16 beats forwarded unchanged; tuser only on beat 0; tlast on beats 3, 7, 11, 15.
  - Required: DRAIN until the 4th mon tlast, then frame_done; the next SOF is accepted.
- 5 junk beats, then SOF: dropped_beats=5; the first forwarded beat carries tuser=1.
- Early SOF after 6 beats:
  - Required: err_sof pulse; 10 zero-data beats with tlast on beats 7, 11, 15; DRAIN.
  - Required: after frame_done, the held SOF beat starts the next frame.
- Input tlast asserted on beat 2: err_eol pulses for one cycle; output tlast is still on beat 3.
- Random m_axis_tready and s_axis_tvalid throttling:
  - Required: no beat lost or duplicated; the data sequence matches the input.
  - Required: switch_img_in toggled mid-frame leaves switch_img_out unchanged until the next frame start.
- aresetn=0 for one cycle at beat 9:
  - Required: all outputs 0 and state SEEK; the next frame is forwarded intact.
